// File: rtl/pll_reset_pkg.sv
// Purpose: shared state encoding, parameter defaults and widths for the PLL reset sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a (no data path).
package pll_reset_pkg;

    typedef enum logic [1:0] {
        WAIT_LOCK = 2'd0,
        STABLE    = 2'd1,
        RELEASE   = 2'd2,
        RUN       = 2'd3
    } state_e;

    localparam int DEF_SYNC_STAGES        = 2;
    localparam int DEF_LOCK_STABLE_CYCLES = 1024;
    localparam int DEF_STAGE_GAP_CYCLES   = 16;
    localparam int DEF_NUM_STAGES         = 4;

    // Width of the saturating lock-loss counter.
    localparam int LOSS_CNT_W = 8;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/sync_bit.sv
// Purpose: multi-flop synchronizer for one asynchronous level signal.
// Latency: STAGES clk edges from d_i to q_o.
// Backpressure: none; free-running, samples every cycle.
//
// Ports: clk_i (destination clock), rst_ni (async active-low clear),
//        d_i (asynchronous input), q_o (synchronized output).
module sync_bit #(
    parameter int STAGES = 2
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic d_i,
    output logic q_o
);

    logic [STAGES-1:0] sync_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d_i};
        end
    end

    assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/pll_reset_seq.sv
// Purpose: qualify PLL lock, then release staged downstream resets one gap apart.
// Latency: first stage released LOCK_STABLE_CYCLES edges after locked_s is seen; abort takes one edge.
// Backpressure: none; soft_reset_req is a single-cycle pulse, lock loss aborts immediately.
//
// Ports: clk, reset_n (async active-low), locked_in (async PLL lock),
//        soft_reset_req (sync restart pulse), rst_out_n[NUM_STAGES] (bit 0 released first),
//        ready (all stages released), lock_loss_count (saturating lock-loss counter).
module pll_reset_seq
    import pll_reset_pkg::*;
#(
    parameter int SYNC_STAGES        = DEF_SYNC_STAGES,
    parameter int LOCK_STABLE_CYCLES = DEF_LOCK_STABLE_CYCLES,
    parameter int STAGE_GAP_CYCLES   = DEF_STAGE_GAP_CYCLES,
    parameter int NUM_STAGES         = DEF_NUM_STAGES
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  locked_in,
    input  logic                  soft_reset_req,
    output logic [NUM_STAGES-1:0] rst_out_n,
    output logic                  ready,
    output logic [LOSS_CNT_W-1:0] lock_loss_count
);

    // One counter serves both the lock-qualification window and the stage gaps.
    localparam int CNT_W =
        $clog2(max_int(LOCK_STABLE_CYCLES, STAGE_GAP_CYCLES * NUM_STAGES)) + 1;

    localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(LOCK_STABLE_CYCLES - 1);
    // Counter value (after increment) at which the last stage is released.
    localparam logic [CNT_W-1:0] LAST_GAP    = CNT_W'((NUM_STAGES - 1) * STAGE_GAP_CYCLES);
    localparam logic [LOSS_CNT_W-1:0] LOSS_MAX = {LOSS_CNT_W{1'b1}};

    logic                  locked_s;
    state_e                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [CNT_W-1:0]      cnt_inc;
    logic [NUM_STAGES-1:0] rst_q, rst_d;
    logic                  ready_q, ready_d;
    logic [LOSS_CNT_W-1:0] loss_q, loss_d;

    sync_bit #(
        .STAGES (SYNC_STAGES)
    ) u_lock_sync (
        .clk_i  (clk),
        .rst_ni (reset_n),
        .d_i    (locked_in),
        .q_o    (locked_s)
    );

    assign cnt_inc = cnt_q + CNT_W'(1);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= WAIT_LOCK;
            cnt_q   <= '0;
            rst_q   <= '0;
            ready_q <= 1'b0;
            loss_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rst_q   <= rst_d;
            ready_q <= ready_d;
            loss_q  <= loss_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rst_d   = rst_q;
        ready_d = ready_q;
        loss_d  = loss_q;

        case (state_q)
            WAIT_LOCK: begin
                cnt_d   = '0;
                rst_d   = '0;
                ready_d = 1'b0;
                if (locked_s) begin
                    state_d = STABLE;
                end
            end

            STABLE: begin
                if (!locked_s || soft_reset_req) begin
                    // Lock never qualified, so this is not counted as a loss.
                    state_d = WAIT_LOCK;
                    cnt_d   = '0;
                end else if (cnt_q == STABLE_LAST) begin
                    state_d  = RELEASE;
                    cnt_d    = '0;
                    rst_d[0] = 1'b1;
                end else begin
                    cnt_d = cnt_inc;
                end
            end

            RELEASE, RUN: begin
                if (!locked_s || soft_reset_req) begin
                    state_d = WAIT_LOCK;
                    cnt_d   = '0;
                    rst_d   = '0;
                    ready_d = 1'b0;
                    if (!locked_s && (loss_q != LOSS_MAX)) begin
                        loss_d = loss_q + LOSS_CNT_W'(1);
                    end
                end else if (state_q == RELEASE) begin
                    cnt_d = cnt_inc;
                    // Stage k goes high when k gaps have elapsed since stage 0.
                    for (int k = 1; k < NUM_STAGES; k++) begin
                        if (cnt_inc == CNT_W'(k * STAGE_GAP_CYCLES)) begin
                            rst_d[k] = 1'b1;
                        end
                    end
                    // A single stage has nothing left to release, so RUN follows next edge.
                    if ((NUM_STAGES == 1) || (cnt_inc == LAST_GAP)) begin
                        state_d = RUN;
                        ready_d = 1'b1;
                    end
                end
            end

            default: begin
                state_d = WAIT_LOCK;
            end
        endcase
    end

    assign rst_out_n       = rst_q;
    assign ready           = ready_q;
    assign lock_loss_count = loss_q;

endmodule

// File: tb/tb_pll_reset_seq.sv
module tb_pll_reset_seq;

    localparam int SYNC = 2;
    localparam int LS   = 8;
    localparam int GAP  = 4;
    localparam int NUM  = 4;

    logic           clk = 1'b0;
    logic           reset_n = 1'b0;
    logic           locked_in = 1'b0;
    logic           soft_reset_req = 1'b0;
    logic [NUM-1:0] rst_out_n;
    logic           ready;
    logic [7:0]     lock_loss_count;

    int checks = 0;
    int errors = 0;

    // Reference model: tracks edge numbers of lock qualification and release start,
    // derives outputs from elapsed edge counts.
    int             edge_n;
    int             m_qual;   // edge at which qualification window began, -1 if none
    int             m_rel;    // edge at which stage 0 was released, -1 if not released
    int             m_loss;
    logic           m_s1, m_s2;
    logic [NUM-1:0] exp_rst;
    logic           exp_ready;
    logic [7:0]     exp_loss;

    pll_reset_seq #(
        .SYNC_STAGES        (SYNC),
        .LOCK_STABLE_CYCLES (LS),
        .STAGE_GAP_CYCLES   (GAP),
        .NUM_STAGES         (NUM)
    ) dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .locked_in       (locked_in),
        .soft_reset_req  (soft_reset_req),
        .rst_out_n       (rst_out_n),
        .ready           (ready),
        .lock_loss_count (lock_loss_count)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        edge_n    = 0;
        m_qual    = -1;
        m_rel     = -1;
        m_loss    = 0;
        m_s1      = 1'b0;
        m_s2      = 1'b0;
        exp_rst   = '0;
        exp_ready = 1'b0;
        exp_loss  = 8'd0;
    endtask

    task automatic apply_reset();
        #2;
        reset_n        = 1'b0;
        locked_in      = 1'b0;
        soft_reset_req = 1'b0;
        model_reset();
        #10;
        reset_n = 1'b1;
    endtask

    // Drive one cycle of inputs, advance one edge, update the reference model.
    task automatic tick(input logic lk, input logic sr);
        logic ls;
        locked_in      = lk;
        soft_reset_req = sr;
        @(posedge clk);
        #1;
        edge_n++;
        ls   = m_s2;
        m_s2 = m_s1;
        m_s1 = lk;
        if (m_rel >= 0) begin
            if (!ls || sr) begin
                if (!ls && m_loss < 255) m_loss++;
                m_rel  = -1;
                m_qual = -1;
            end
        end else if (m_qual >= 0) begin
            if (!ls || sr) m_qual = -1;
            else if (edge_n - m_qual == LS) m_rel = edge_n;
        end else if (ls) begin
            m_qual = edge_n;
        end
        exp_rst   = '0;
        exp_ready = 1'b0;
        if (m_rel >= 0) begin
            for (int k = 0; k < NUM; k++) exp_rst[k] = ((edge_n - m_rel) >= k * GAP);
            exp_ready = ((edge_n - m_rel) >= (NUM - 1) * GAP);
        end
        exp_loss = 8'(m_loss);
        soft_reset_req = 1'b0;
    endtask

    task automatic test_reset();
        #1;
        checks++;
        if (rst_out_n !== 4'b0000 || ready !== 1'b0 || lock_loss_count !== 8'd0) begin
            errors++;
            $display("FAIL reset_state got rst=%b rdy=%b loss=%0d want 0000/0/0",
                     rst_out_n, ready, lock_loss_count);
        end
        apply_reset();
        tick(1'b1, 1'b0);
        checks++;
        if (rst_out_n !== 4'b0000 || ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_first_edge got rst=%b rdy=%b want 0000/0", rst_out_n, ready);
        end
    endtask

    task automatic test_power_up();
        int             pe  [7] = '{10, 11, 14, 15, 19, 22, 23};
        logic [NUM-1:0] pr  [7] = '{4'b0000, 4'b0001, 4'b0001, 4'b0011, 4'b0111, 4'b0111, 4'b1111};
        logic           prd [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        apply_reset();
        for (int e = 1; e <= 30; e++) begin
            tick(1'b1, 1'b0);
            checks++;
            if (rst_out_n !== exp_rst || ready !== exp_ready || lock_loss_count !== exp_loss) begin
                errors++;
                $display("FAIL power_up_model e=%0d got %b/%b/%0d want %b/%b/%0d",
                         e, rst_out_n, ready, lock_loss_count, exp_rst, exp_ready, exp_loss);
            end
            for (int j = 0; j < 7; j++) begin
                if (pe[j] == e) begin
                    checks++;
                    if (rst_out_n !== pr[j] || ready !== prd[j]) begin
                        errors++;
                        $display("FAIL power_up_edge e=%0d got rst=%b rdy=%b want rst=%b rdy=%b",
                                 e, rst_out_n, ready, pr[j], prd[j]);
                    end
                end
            end
        end
    endtask

    task automatic test_lock_glitch();
        apply_reset();
        for (int e = 1; e <= 32; e++) begin
            tick((e == 7) ? 1'b0 : 1'b1, 1'b0);
            checks++;
            if (rst_out_n !== exp_rst || ready !== exp_ready || lock_loss_count !== exp_loss) begin
                errors++;
                $display("FAIL glitch_model e=%0d got %b/%b/%0d want %b/%b/%0d",
                         e, rst_out_n, ready, lock_loss_count, exp_rst, exp_ready, exp_loss);
            end
            if (e == 17 || e == 18) begin
                checks++;
                if (rst_out_n !== ((e == 18) ? 4'b0001 : 4'b0000)) begin
                    errors++;
                    $display("FAIL glitch_restart e=%0d got rst=%b", e, rst_out_n);
                end
            end
        end
        checks++;
        if (lock_loss_count !== 8'd0) begin
            errors++;
            $display("FAIL glitch_loss got %0d want 0", lock_loss_count);
        end
    endtask

    task automatic test_lock_loss_run();
        int n;
        apply_reset();
        n = 0;
        while (!exp_ready && n < 40) begin
            tick(1'b1, 1'b0);
            n++;
        end
        tick(1'b0, 1'b0);
        tick(1'b1, 1'b0);
        checks++;
        if (rst_out_n !== 4'b1111 || ready !== 1'b1) begin
            errors++;
            $display("FAIL loss_before got rst=%b rdy=%b want 1111/1", rst_out_n, ready);
        end
        tick(1'b1, 1'b0);
        checks++;
        if (rst_out_n !== 4'b0000 || ready !== 1'b0 || lock_loss_count !== 8'd1) begin
            errors++;
            $display("FAIL loss_abort got rst=%b rdy=%b loss=%0d want 0000/0/1",
                     rst_out_n, ready, lock_loss_count);
        end
        n = 2;
        while (ready !== 1'b1 && n < 60) begin
            tick(1'b1, 1'b0);
            n++;
            checks++;
            if (rst_out_n !== exp_rst || ready !== exp_ready || lock_loss_count !== exp_loss) begin
                errors++;
                $display("FAIL loss_resequence n=%0d got %b/%b/%0d want %b/%b/%0d",
                         n, rst_out_n, ready, lock_loss_count, exp_rst, exp_ready, exp_loss);
            end
        end
        checks++;
        if (n != 23) begin
            errors++;
            $display("FAIL loss_ready_delay got %0d edges want 23", n);
        end
    endtask

    task automatic test_soft_reset();
        int   n;
        logic [7:0] l0;
        apply_reset();
        n = 0;
        while (!exp_ready && n < 40) begin tick(1'b1, 1'b0); n++; end
        l0 = exp_loss;
        tick(1'b0, 1'b0);
        tick(1'b1, 1'b0);
        tick(1'b1, 1'b1);   // soft request on the edge that sees the lock drop
        checks++;
        if (lock_loss_count !== l0 + 8'd1 || rst_out_n !== 4'b0000 || ready !== 1'b0) begin
            errors++;
            $display("FAIL soft_with_loss got loss=%0d rst=%b rdy=%b want loss=%0d 0000/0",
                     lock_loss_count, rst_out_n, ready, l0 + 8'd1);
        end
        n = 0;
        while (!exp_ready && n < 40) begin tick(1'b1, 1'b0); n++; end
        l0 = exp_loss;
        tick(1'b1, 1'b1);
        checks++;
        if (lock_loss_count !== l0 || rst_out_n !== 4'b0000 || ready !== 1'b0) begin
            errors++;
            $display("FAIL soft_alone got loss=%0d rst=%b rdy=%b want loss=%0d 0000/0",
                     lock_loss_count, rst_out_n, ready, l0);
        end
        for (int e = 1; e <= 26; e++) begin
            tick(1'b1, 1'b0);
            checks++;
            if (rst_out_n !== exp_rst || ready !== exp_ready || lock_loss_count !== exp_loss) begin
                errors++;
                $display("FAIL soft_restart e=%0d got %b/%b/%0d want %b/%b/%0d",
                         e, rst_out_n, ready, lock_loss_count, exp_rst, exp_ready, exp_loss);
            end
        end
    endtask

    task automatic test_saturation();
        int drops;
        int cool;
        logic lk;
        apply_reset();
        drops = 0;
        cool  = 0;
        for (int t = 0; t < 6000 && drops < 260; t++) begin
            lk = 1'b1;
            if (cool > 0) cool--;
            else if (exp_rst[0]) begin
                lk    = 1'b0;
                cool  = 3;
                drops++;
            end
            tick(lk, 1'b0);
            checks++;
            if (rst_out_n !== exp_rst || ready !== exp_ready || lock_loss_count !== exp_loss) begin
                errors++;
                $display("FAIL sat_model t=%0d got %b/%b/%0d want %b/%b/%0d",
                         t, rst_out_n, ready, lock_loss_count, exp_rst, exp_ready, exp_loss);
            end
        end
        tick(1'b1, 1'b0);
        tick(1'b1, 1'b0);
        checks++;
        if (drops != 260 || lock_loss_count !== 8'd255) begin
            errors++;
            $display("FAIL saturation got drops=%0d loss=%0d want 260/255", drops, lock_loss_count);
        end
    endtask

    task automatic test_async_reset_mid_release();
        int n;
        n = 0;
        while (exp_rst !== 4'b0011 && n < 60) begin tick(1'b1, 1'b0); n++; end
        checks++;
        if (rst_out_n !== 4'b0011 || lock_loss_count === 8'd0) begin
            errors++;
            $display("FAIL async_setup got rst=%b loss=%0d want 0011 and nonzero loss",
                     rst_out_n, lock_loss_count);
        end
        #2;
        reset_n = 1'b0;
        #1;
        checks++;
        if (rst_out_n !== 4'b0000 || ready !== 1'b0 || lock_loss_count !== 8'd0) begin
            errors++;
            $display("FAIL async_reset got rst=%b rdy=%b loss=%0d want 0000/0/0",
                     rst_out_n, ready, lock_loss_count);
        end
        #4;
        apply_reset();
    endtask

    task automatic test_random();
        logic sr_prev;
        logic lk, sr;
        apply_reset();
        sr_prev = 1'b0;
        for (int t = 0; t < 3000; t++) begin
            lk = ($urandom_range(0, 49) != 0);
            sr = !sr_prev && ($urandom_range(0, 79) == 0);
            sr_prev = sr;
            tick(lk, sr);
            checks++;
            if (rst_out_n !== exp_rst || ready !== exp_ready || lock_loss_count !== exp_loss) begin
                errors++;
                $display("FAIL random t=%0d got %b/%b/%0d want %b/%b/%0d",
                         t, rst_out_n, ready, lock_loss_count, exp_rst, exp_ready, exp_loss);
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_power_up();
        test_lock_glitch();
        test_lock_loss_run();
        test_soft_reset();
        test_saturation();
        test_async_reset_mid_release();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pll_reset_seq.md
PLL_RESET_SEQ -- requirements
Module: pll_reset_seq

Interface
REQ-001 Parameter SYNC_STAGES, default 2: flops in the locked_in synchronizer, at least 2.
REQ-002 Parameter LOCK_STABLE_CYCLES, default 1024: consecutive synchronized-lock cycles required before any reset is released, at least 1.
REQ-003 Parameter STAGE_GAP_CYCLES, default 16: cycles between successive stage releases, at least 1.
REQ-004 Parameter NUM_STAGES, default 4: number of staged reset outputs, 1 to 8.
REQ-005 clk  in  1  system clock, the PLL primary output; the block's only clock.
REQ-006 reset_n  in  1  asynchronous active-low reset.
REQ-007 locked_in  in  1  PLL lock indicator, asynchronous to clk.
REQ-008 soft_reset_req  in  1  single-cycle pulse, synchronous to clk, that restarts the sequence.
REQ-009 rst_out_n  out  NUM_STAGES  active-low reset per downstream stage; bit 0 released first.
REQ-010 ready  out  1  high while all stages are released.
REQ-011 lock_loss_count  out  8  count of lock losses after release began; saturates at 255.

Function
REQ-012 locked_in shall pass through a SYNC_STAGES-flop synchronizer; its output is locked_s.
REQ-013 The FSM shall have four states: WAIT_LOCK, STABLE, RELEASE and RUN.
REQ-014 WAIT_LOCK: all rst_out_n are 0, ready is 0 and the cycle counter is cleared; locked_s=1 moves the FSM to STABLE on the next edge with the counter at 0.
REQ-015 STABLE: the counter increments each cycle; locked_s=0 or soft_reset_req=1 returns the FSM to WAIT_LOCK; counter equal to LOCK_STABLE_CYCLES-1 with locked_s=1 enters RELEASE.
REQ-016 rst_out_n[0] shall rise on the same edge that enters RELEASE.
REQ-017 In RELEASE, rst_out_n[k] shall rise exactly k*STAGE_GAP_CYCLES edges after rst_out_n[0]; released bits stay at 1.
REQ-018 The edge that raises rst_out_n[NUM_STAGES-1] shall enter RUN and raise ready; with NUM_STAGES=1, RUN and ready follow one edge after entering RELEASE.
REQ-019 In RELEASE or RUN, locked_s=0 or soft_reset_req=1 shall drive all rst_out_n to 0 and ready to 0 on the next edge and enter WAIT_LOCK.
REQ-020 lock_loss_count shall increment by exactly 1 when locked_s=0 is sampled in RELEASE or RUN, including when soft_reset_req coincides; it shall never wrap past 255.
REQ-021 soft_reset_req alone shall never change lock_loss_count.
REQ-022 A lock drop in STABLE shall not change lock_loss_count.
REQ-023 All outputs shall be registered; no combinational path from any input to any output.
REQ-024 The counter shall be clog2(max(LOCK_STABLE_CYCLES, STAGE_GAP_CYCLES*NUM_STAGES))+1 bits wide and shall be reused across STABLE and RELEASE.

Reset
REQ-025 Assertion of reset_n shall asynchronously set the state to WAIT_LOCK and clear the synchronizer, the counter, rst_out_n, ready and lock_loss_count.
REQ-026 Deassertion of reset_n shall be honored on a clk edge; the sequence then restarts from WAIT_LOCK regardless of locked_in.

Structure
REQ-027 The package pll_reset_pkg shall hold the state enum (WAIT_LOCK, STABLE, RELEASE, RUN), the parameter defaults and the loss-counter width constant.
REQ-028 The synchronizer shall be a separate sub-module, sync_bit (parameterized depth, async active-low clear), instantiated once.

Verification
Bench parameters: SYNC=2, LOCK_STABLE=8, GAP=4, NUM=4.
REQ-029 Power-up: locked_in=1 from reset release -> rst_out_n[0] rises at edge 11, bits 1/2/3 at edges 15/19/23, and ready rises at edge 23.
REQ-030 Lock glitch: locked_s drops at STABLE count 5 -> FSM returns to WAIT_LOCK, the full 8-cycle count restarts, and lock_loss_count stays 0.
REQ-031 Lock loss in RUN -> rst_out_n=0000 and ready=0 one edge after locked_s falls, and lock_loss_count=1; lock returns -> the full sequence repeats.
REQ-032 soft_reset_req in the cycle where locked_s=0 in RUN -> lock_loss_count increments by exactly 1; soft_reset_req alone in RUN -> count unchanged and the sequence restarts.
REQ-033 Saturation: 260 lock losses in RUN -> lock_loss_count=255.
REQ-034 reset_n asserted mid-RELEASE with rst_out_n=0011 -> rst_out_n=0000, ready=0 and count=0 immediately, without waiting for a clk edge.
